// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode and immediate-format definitions for the RV32I/RV64I
// immediate generator.
package imm_gen_pipe_pkg;

  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] I_TYPE    = 7'b0000011;
  localparam logic [6:0] S_TYPE    = 7'b0100011;
  localparam logic [6:0] R_IMM     = 7'b0010011;
  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] SYSTEM    = 7'b1110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// Illegal encodings always report FMT_NONE with a zero immediate.
module imm_decode_comb
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_fmt,
  output logic            o_illegal
);

  logic [6:0] w_opcode;
  logic       w_is_shift;
  logic [5:0] w_shamt;
  imm_fmt_e   w_fmt;

  assign w_opcode   = i_instr[6:0];
  assign w_is_shift = (i_instr[13:12] == 2'b01);
  assign w_shamt    = (XLEN == 64) ? i_instr[25:20] : {1'b0, i_instr[24:20]};
  assign o_fmt      = w_fmt;

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  always_comb begin
    o_imm     = '0;
    w_fmt     = FMT_NONE;
    o_illegal = 1'b0;
    if (i_instr[1:0] != 2'b11) begin
      o_illegal = 1'b1;
    end else begin
      case (w_opcode)
        LUI, AUIPC: begin
          w_fmt = FMT_U;
          o_imm = sext({i_instr[31:12], 12'b0});
        end
        JAL: begin
          w_fmt = FMT_J;
          o_imm = sext({{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                        i_instr[20], i_instr[30:21], 1'b0});
        end
        JALR, I_TYPE, SYSTEM: begin
          w_fmt = FMT_I;
          o_imm = sext({{20{i_instr[31]}}, i_instr[31:20]});
        end
        B_TYPE: begin
          w_fmt = FMT_B;
          o_imm = sext({{19{i_instr[31]}}, i_instr[31], i_instr[7],
                        i_instr[30:25], i_instr[11:8], 1'b0});
        end
        S_TYPE: begin
          w_fmt = FMT_S;
          o_imm = sext({{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]});
        end
        R_IMM: begin
          if (w_is_shift) begin
            // RV32 has only a 5-bit shamt, so bit 25 must be clear
            if (XLEN == 32 && i_instr[25]) begin
              o_illegal = 1'b1;
            end else begin
              w_fmt = FMT_SHAMT;
              o_imm = XLEN'(w_shamt);
            end
          end else begin
            w_fmt = FMT_I;
            o_imm = sext({{20{i_instr[31]}}, i_instr[31:20]});
          end
        end
        R_TYPE: w_fmt = FMT_NONE;
        OP_IMM_32: begin
          if (XLEN != 64) begin
            o_illegal = 1'b1;
          end else if (w_is_shift) begin
            if (i_instr[25]) begin
              o_illegal = 1'b1;
            end else begin
              w_fmt = FMT_SHAMT;
              o_imm = XLEN'(i_instr[24:20]);
            end
          end else begin
            w_fmt = FMT_I;
            o_imm = sext({{20{i_instr[31]}}, i_instr[31:20]});
          end
        end
        OP_32: begin
          if (XLEN != 64) o_illegal = 1'b1;
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator with a registered output stage and a one-entry skid
// register so that in_ready comes straight from a flop.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  logic [XLEN-1:0]  w_imm;
  logic [2:0]       w_fmt;
  logic             w_illegal;
  logic             w_accept;
  logic             w_emit;

  logic             r_out_valid;
  logic [XLEN-1:0]  r_out_imm;
  logic [2:0]       r_out_fmt;
  logic             r_out_illegal;
  logic [TAG_W-1:0] r_out_tag;

  logic             r_skid_valid;
  logic [XLEN-1:0]  r_skid_imm;
  logic [2:0]       r_skid_fmt;
  logic             r_skid_illegal;
  logic [TAG_W-1:0] r_skid_tag;

  imm_decode_comb #(.XLEN(XLEN)) u_decode (
    .i_instr   (in_instr),
    .o_imm     (w_imm),
    .o_fmt     (w_fmt),
    .o_illegal (w_illegal)
  );

  assign in_ready    = ~r_skid_valid;
  assign w_accept    = in_valid & in_ready;
  assign w_emit      = r_out_valid & out_ready;

  assign out_valid   = r_out_valid;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_illegal = r_out_illegal;
  assign out_tag     = r_out_tag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid    <= 1'b0;
      r_out_imm      <= '0;
      r_out_fmt      <= FMT_NONE;
      r_out_illegal  <= 1'b0;
      r_out_tag      <= '0;
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= FMT_NONE;
      r_skid_illegal <= 1'b0;
      r_skid_tag     <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_emit && r_skid_valid) begin
      // in_ready is low here, so no new instruction competes for OUT
      r_out_valid   <= 1'b1;
      r_out_imm     <= r_skid_imm;
      r_out_fmt     <= r_skid_fmt;
      r_out_illegal <= r_skid_illegal;
      r_out_tag     <= r_skid_tag;
      r_skid_valid  <= 1'b0;
    end else if (w_emit || !r_out_valid) begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_imm     <= w_imm;
        r_out_fmt     <= w_fmt;
        r_out_illegal <= w_illegal;
        r_out_tag     <= in_tag;
      end
    end else if (w_accept) begin
      r_skid_valid   <= 1'b1;
      r_skid_imm     <= w_imm;
      r_skid_fmt     <= w_fmt;
      r_skid_illegal <= w_illegal;
      r_skid_tag     <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench driving an XLEN=32 and an XLEN=64 instance with a common stream;
// each has its own scoreboard of expected results.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;
  logic [7:0]  in_tag;

  logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
  logic [31:0] imm32;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;
  logic [7:0]  tag32, tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32), .out_tag(tag32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(vld64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64), .out_tag(tag64));

  typedef struct packed {
    logic [7:0]  tag;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w, input logic [7:0] t, input bit x64);
    exp_t       e;
    logic [31:0] v;
    logic [2:0]  f;
    logic        il;
    v = 32'h0; f = 3'd0; il = 1'b0;
    if (w[1:0] != 2'b11) il = 1'b1;
    else begin
      case (w[6:0])
        7'h37, 7'h17: begin f = 3'd4; v = {w[31:12], 12'h0}; end
        7'h6F: begin f = 3'd5; v = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
        7'h67, 7'h03, 7'h73: begin f = 3'd1; v = {{20{w[31]}}, w[31:20]}; end
        7'h63: begin f = 3'd3; v = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; end
        7'h23: begin f = 3'd2; v = {{20{w[31]}}, w[31:25], w[11:7]}; end
        7'h13: begin
          if (w[13:12] == 2'b01) begin
            if (!x64 && w[25]) il = 1'b1;
            else begin f = 3'd6; v = x64 ? {26'h0, w[25:20]} : {27'h0, w[24:20]}; end
          end else begin f = 3'd1; v = {{20{w[31]}}, w[31:20]}; end
        end
        7'h33: f = 3'd0;
        7'h1B: begin
          if (!x64) il = 1'b1;
          else if (w[13:12] == 2'b01) begin
            if (w[25]) il = 1'b1;
            else begin f = 3'd6; v = {27'h0, w[24:20]}; end
          end else begin f = 3'd1; v = {{20{w[31]}}, w[31:20]}; end
        end
        7'h3B: if (!x64) il = 1'b1;
        default: il = 1'b1;
      endcase
    end
    e.tag = t;
    e.fmt = il ? 3'd0 : f;
    e.ill = il;
    e.imm = il ? 64'h0 : (x64 ? {{32{v[31]}}, v} : {32'h0, v});
    return e;
  endfunction

  // Scoreboard: decisions for the coming posedge, sampled at negedge
  always @(negedge clk) begin
    exp_t e;
    if (rst || flush) begin
      q32.delete();
      q64.delete();
    end else begin
      if (vld32 && out_ready) begin
        if (q32.size() == 0) chk("sb32_underflow", 64'(q32.size()), 64'd1);
        else begin
          e = q32.pop_front();
          chk("sb32_tag", {56'h0, tag32}, {56'h0, e.tag});
          chk("sb32_imm", {32'h0, imm32}, e.imm);
          chk("sb32_fmt", {61'h0, fmt32}, {61'h0, e.fmt});
          chk("sb32_ill", {63'h0, ill32}, {63'h0, e.ill});
        end
      end
      if (vld64 && out_ready) begin
        if (q64.size() == 0) chk("sb64_underflow", 64'(q64.size()), 64'd1);
        else begin
          e = q64.pop_front();
          chk("sb64_tag", {56'h0, tag64}, {56'h0, e.tag});
          chk("sb64_imm", imm64, e.imm);
          chk("sb64_fmt", {61'h0, fmt64}, {61'h0, e.fmt});
          chk("sb64_ill", {63'h0, ill64}, {63'h0, e.ill});
        end
      end
      if (in_valid && rdy32) q32.push_back(model(in_instr, in_tag, 1'b0));
      if (in_valid && rdy64) q64.push_back(model(in_instr, in_tag, 1'b1));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_vld32"}, {63'h0, vld32}, 64'h0);
    chk({name, "_imm32"}, {32'h0, imm32}, 64'h0);
    chk({name, "_fmt32"}, {61'h0, fmt32}, 64'h0);
    chk({name, "_ill32"}, {63'h0, ill32}, 64'h0);
    chk({name, "_tag32"}, {56'h0, tag32}, 64'h0);
    chk({name, "_rdy32"}, {63'h0, rdy32}, 64'h1);
    chk({name, "_vld64"}, {63'h0, vld64}, 64'h0);
    chk({name, "_imm64"}, imm64, 64'h0);
    chk({name, "_rdy64"}, {63'h0, rdy64}, 64'h1);
  endtask

  typedef struct {
    logic [31:0] w;
    logic [31:0] i32; logic [2:0] f32; logic l32;
    logic [63:0] i64; logic [2:0] f64; logic l64;
  } dir_t;

  dir_t dir[18];
  logic [6:0] ops[13];

  initial begin
    dir[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    dir[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0};
    dir[2]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0, 64'h0000000012345000, 3'd4, 1'b0};
    dir[3]  = '{32'h800000B7, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0};
    dir[4]  = '{32'h02009093, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000020, 3'd6, 1'b0};
    dir[5]  = '{32'h4200D093, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000020, 3'd6, 1'b0};
    dir[6]  = '{32'h41F0D093, 32'h0000001F, 3'd6, 1'b0, 64'h000000000000001F, 3'd6, 1'b0};
    dir[7]  = '{32'hFFF0809B, 32'h00000000, 3'd0, 1'b1, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    dir[8]  = '{32'h0200909B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    dir[9]  = '{32'h0010909B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000001, 3'd6, 1'b0};
    dir[10] = '{32'h00000033, 32'h00000000, 3'd0, 1'b0, 64'h0000000000000000, 3'd0, 1'b0};
    dir[11] = '{32'h00000000, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b1};
    dir[12] = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd2, 1'b0};
    dir[13] = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0};
    dir[14] = '{32'h0000003B, 32'h00000000, 3'd0, 1'b1, 64'h0000000000000000, 3'd0, 1'b0};
    dir[15] = '{32'hFFF02003, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0};
    dir[16] = '{32'h7FF00073, 32'h000007FF, 3'd1, 1'b0, 64'h00000000000007FF, 3'd1, 1'b0};
    dir[17] = '{32'hFFFFF017, 32'hFFFFF000, 3'd4, 1'b0, 64'hFFFFFFFFFFFFF000, 3'd4, 1'b0};
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
            7'h33, 7'h73, 7'h1B, 7'h3B, 7'h7F};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_tag = 8'h0;
    #1;
    chk_zero("reset");
    #11 rst = 1'b0;
    tick();

    // Directed decode, one result visible one cycle after acceptance
    for (int k = 0; k < 18; k++) begin
      in_valid = 1'b1; in_instr = dir[k].w; in_tag = 8'(k + 1);
      tick();
      in_valid = 1'b0;
      chk("dir_vld32", {63'h0, vld32}, 64'h1);
      chk("dir_tag32", {56'h0, tag32}, 64'(k + 1));
      chk("dir_imm32", {32'h0, imm32}, {32'h0, dir[k].i32});
      chk("dir_fmt32", {61'h0, fmt32}, {61'h0, dir[k].f32});
      chk("dir_ill32", {63'h0, ill32}, {63'h0, dir[k].l32});
      chk("dir_imm64", imm64, dir[k].i64);
      chk("dir_fmt64", {61'h0, fmt64}, {61'h0, dir[k].f64});
      chk("dir_ill64", {63'h0, ill64}, {63'h0, dir[k].l64});
    end
    tick();

    // Backpressure: OUT and SKID fill, third word is held off
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      in_valid = 1'b1; in_instr = dir[t].w; in_tag = 8'(t);
      tick();
    end
    chk("bp_vld", {63'h0, vld32}, 64'h1);
    chk("bp_tag_out", {56'h0, tag32}, 64'd1);
    chk("bp_rdy32", {63'h0, rdy32}, 64'h0);
    chk("bp_rdy64", {63'h0, rdy64}, 64'h0);
    out_ready = 1'b1;
    tick();
    chk("bp_tag2", {56'h0, tag32}, 64'd2);
    chk("bp_rdy_back", {63'h0, rdy32}, 64'h1);
    tick();
    in_valid = 1'b0;
    chk("bp_tag3", {56'h0, tag32}, 64'd3);
    tick();
    chk("bp_empty", {63'h0, vld32}, 64'h0);

    // Throughput: one per cycle with ready never dropping
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_instr = $urandom; in_tag = 8'(16 + i);
      tick();
      chk("tp_rdy", {63'h0, rdy32 & rdy64}, 64'h1);
      chk("tp_vld", {63'h0, vld32 & vld64}, 64'h1);
      chk("tp_tag", {56'h0, tag32}, 64'(16 + i));
    end
    in_valid = 1'b0;
    tick();

    // Flush with both entries full and a word on the input
    out_ready = 1'b0;
    for (int t = 40; t <= 41; t++) begin
      in_valid = 1'b1; in_instr = dir[t - 40].w; in_tag = 8'(t);
      tick();
    end
    in_tag = 8'd42; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_vld32", {63'h0, vld32}, 64'h0);
    chk("fl_vld64", {63'h0, vld64}, 64'h0);
    chk("fl_rdy", {63'h0, rdy32}, 64'h1);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("fl_gone", {63'h0, vld32 | vld64}, 64'h0);

    // Asynchronous reset between edges with two entries held
    out_ready = 1'b0;
    for (int t = 50; t <= 51; t++) begin
      in_valid = 1'b1; in_instr = dir[t - 48].w; in_tag = 8'(t);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_zero("arst");
    #3 rst = 1'b0;
    tick();
    in_valid = 1'b1; in_instr = dir[0].w; in_tag = 8'd52; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("arst_lat_vld", {63'h0, vld32}, 64'h1);
    chk("arst_lat_tag", {56'h0, tag32}, 64'd52);
    tick();

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      in_instr  = {$urandom_range(0, 32'h1FFFFFF), ops[$urandom_range(0, 12)]};
      in_tag    = 8'(i);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain64", 64'(q64.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Pipelined, XLEN-parametrised immediate generator for the RV32I/RV64I decode stage.
- Accepts a raw 32-bit instruction plus an opaque tag over a valid/ready handshake.
- Registers the decoded immediate, an immediate-format code and an illegal-encoding flag.
- A 2-entry skid buffer keeps in_ready driven from a register, so decode can stall without a combinational ready path back to fetch.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; sets out_imm width and shamt width.
- TAG_W, 8, width of the opaque tag (PC index, ROB id, etc.) passed through unchanged.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all buffered entries.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  block can accept; registered, equals ~skid_valid.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  tag travelling with the instruction.
- out_valid  out  1  out_imm/out_fmt/out_illegal/out_tag are valid.
- out_ready  in  1  downstream accepts.
- out_imm  out  XLEN  sign- or zero-extended immediate.
- out_fmt  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT.
- out_illegal  out  1  unrecognised opcode or illegal shamt.
- out_tag  out  TAG_W  tag of the output entry.

Behaviour:
- Reset (async, rst=1): out_valid=0, skid_valid=0, in_ready=1, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0. Reset mid-transfer drops all entries.
- Accept occurs when in_valid & in_ready at the clock edge. Emit occurs when out_valid & out_ready.
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N, provided the output register is empty or emitting.
- State is two entries, the output register (OUT) and the skid register (SKID). Per edge, evaluated in order:
  - Emit and SKID full: OUT <= SKID, SKID empty. In the same edge, an accept is not possible, because in_ready=0.
  - Emit or OUT empty: OUT <= decoded input if accepting, else OUT empty.
  - OUT full, no emit, accepting: SKID <= decoded input, so in_ready falls next cycle.
  - Otherwise hold.
- Simultaneous emit and accept with SKID empty gives full throughput: 1 instruction per cycle.
- flush=1: OUT and SKID empty next cycle, in_ready=1. An accept in the same cycle is discarded. flush has priority over everything except rst.
- Decode is combinational on in_instr; OUT and SKID store already-decoded fields.
- Immediate rules (sext = sign-extend from instr[31] to XLEN):
  - LUI 0110111 and AUIPC 0010111: U, sext({instr[31:12],12'b0}).
  - JAL 1101111: J, sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - JALR 1100111, LOAD 0000011, SYSTEM 1110011: I, sext(instr[31:20]).
  - BRANCH 1100011: B, sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}), including BLTU/BGEU.
  - STORE 0100011: S, sext({instr[31:25],instr[11:7]}).
  - OP-IMM 0010011 with funct3 001 or 101: SHAMT, zero-extended instr[19+log2(XLEN):20].
  - OP-IMM 0010011, other funct3: I, sext(instr[31:20]). SLTIU and SLTI both sign-extend.
  - OP 0110011: NONE, imm=0.
  - Only when XLEN=64: OP-IMM-32 0011011 (shifts give a 5-bit shamt, otherwise I) and OP-32 0111011 (NONE).
- Illegal (out_illegal=1, fmt=NONE, imm=0):
  - Any other opcode, or instr[1:0]!=11.
  - XLEN=32 and a shift with instr[25]=1.
  - An OP-IMM-32 shift with instr[25]=1.
- Illegal entries still flow through the handshake.

Decomposition:
- Shared package (in parameters.v style):
  - Opcode constants LUI, AUIPC, JAL, JALR, B_TYPE, I_TYPE (LOAD), S_TYPE, R_IMM, R_TYPE, SYSTEM, OP_IMM_32, OP_32.
  - Format codes FMT_NONE..FMT_SHAMT.
- One sub-module imm_decode_comb: purely combinational instr -> {imm, fmt, illegal}, parametrised by XLEN.
- The top level holds the skid/handshake logic.

Test Plan:
- XLEN=32, out_ready=1, inputs:
  - 0xFFF00093 (addi -1) -> next cycle out_imm=0xFFFFFFFF, fmt=1.
  - 0xFE000EE3 (beq -4) -> 0xFFFFFFFC, fmt=3.
  - 0x123450B7 -> 0x12345000, fmt=4.
- XLEN=64:
  - 0x800000B7 (lui) -> 0xFFFFFFFF80000000, fmt=4.
  - 0x02009093 (slli 32) -> 0x20, fmt=6, illegal=0.
  - Same word with XLEN=32 -> illegal=1, imm=0.
- Backpressure:
  - Stream tags 1,2,3 with out_ready=0 -> tag1 in OUT, tag2 in SKID, in_ready=0, tag3 not accepted.
  - Then out_ready=1 -> outputs tags 1,2,3 in order, no loss or duplication.
- Throughput: in_valid=out_ready=1 for 16 cycles -> 16 outputs on consecutive cycles, in_ready constantly 1.
- Flush with OUT and SKID full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed tags never appear.
- Reset mid-stream: assert rst asynchronously between edges with 2 entries held -> out_valid=0 and all outputs 0 immediately; after release, the first accept appears with 1-cycle latency.
